// File: rtl/dcache_2way_top.sv
// Two-way set-associative write-back data cache with LRU replacement.
// The CPU side sees zero-latency hits and a combinational stall on a miss.
// The memory side uses a registered request that is held stable until acked.
// A miss runs IDLE -> MISS -> (WRITEBACK) -> READMISS -> READMISSOK -> IDLE,
// after which the retried CPU access hits.
module dcache_2way_top #(
  parameter int LINE_W = 256,
  parameter int SETS   = 32,
  parameter int ADDR_W = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [LINE_W-1:0] mem_data_i,
  input  logic              mem_ack_i,
  output logic [LINE_W-1:0] mem_data_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic              mem_enable_o,
  output logic              mem_write_o,
  input  logic [31:0]       p1_data_i,
  input  logic [ADDR_W-1:0] p1_addr_i,
  input  logic              p1_MemRead_i,
  input  logic              p1_MemWrite_i,
  output logic [31:0]       p1_data_o,
  output logic              p1_stall_o,
  output logic [2:0]        dbg_state
);

  localparam int OFF_W  = $clog2(LINE_W / 8);
  localparam int IDX_W  = $clog2(SETS);
  localparam int TAG_W  = ADDR_W - IDX_W - OFF_W;
  localparam int WORD_W = OFF_W - 2;
  localparam int BIT_W  = $clog2(LINE_W);

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_MISS       = 3'd1,
    S_WRITEBACK  = 3'd2,
    S_READMISS   = 3'd3,
    S_READMISSOK = 3'd4
  } state_t;

  state_t state;

  // Storage: per-way data and tags (not reset), per-set valid/dirty pairs
  // and one LRU bit per set naming the way to evict next.
  logic [LINE_W-1:0] data_mem [2][SETS];
  logic [TAG_W-1:0]  tag_mem  [2][SETS];
  logic [1:0]        valid_q  [SETS];
  logic [1:0]        dirty_q  [SETS];
  logic [SETS-1:0]   lru_q;

  // Miss context captured when leaving IDLE.
  logic [TAG_W-1:0] miss_tag;
  logic [IDX_W-1:0] miss_idx;
  logic             miss_way;

  // CPU address fields.
  logic [TAG_W-1:0]  req_tag;
  logic [IDX_W-1:0]  req_idx;
  logic [WORD_W-1:0] req_word;
  logic [BIT_W-1:0]  word_bit;

  assign req_tag  = p1_addr_i[ADDR_W-1:IDX_W+OFF_W];
  assign req_idx  = p1_addr_i[IDX_W+OFF_W-1:OFF_W];
  assign req_word = p1_addr_i[OFF_W-1:2];
  assign word_bit = {req_word, 5'b0_0000};

  // Byte-lane bits are not used: every access moves a whole 32-bit word.
  logic unused_addr_lsbs;
  assign unused_addr_lsbs = ^p1_addr_i[1:0];

  logic              req;
  logic              hit_w0;
  logic              hit_w1;
  logic              hit;
  logic              hit_way;
  logic              wr_hit;
  logic              fill_we;
  logic [LINE_W-1:0] hit_line;
  logic              vic_way;
  logic              vic_valid;
  logic              vic_dirty;
  logic [TAG_W-1:0]  vic_tag;
  logic [LINE_W-1:0] vic_line;

  assign req     = p1_MemRead_i | p1_MemWrite_i;
  assign hit_w0  = valid_q[req_idx][0] && (tag_mem[0][req_idx] == req_tag);
  assign hit_w1  = valid_q[req_idx][1] && (tag_mem[1][req_idx] == req_tag);
  // Lookups only count in IDLE so a miss in flight never sees a false hit.
  assign hit     = req && (state == S_IDLE) && (hit_w0 || hit_w1);
  assign hit_way = hit_w1;
  assign wr_hit  = hit && p1_MemWrite_i;
  assign fill_we = (state == S_READMISS) && mem_ack_i;

  assign p1_stall_o = req && !hit;
  assign hit_line   = data_mem[hit_way][req_idx];
  assign p1_data_o  = (hit && p1_MemRead_i) ? hit_line[word_bit +: 32] : 32'h0;

  // Victim choice: an empty way (way 0 first), otherwise the LRU way.
  assign vic_way   = !valid_q[req_idx][0] ? 1'b0 :
                     !valid_q[req_idx][1] ? 1'b1 : lru_q[req_idx];
  assign vic_valid = valid_q[miss_idx][miss_way];
  assign vic_dirty = dirty_q[miss_idx][miss_way];
  assign vic_tag   = tag_mem[miss_way][miss_idx];
  assign vic_line  = data_mem[miss_way][miss_idx];

  assign dbg_state = state;

  // Data and tag arrays: line fill from memory or single-word CPU write hit.
  always_ff @(posedge clk_i) begin
    if (fill_we) begin
      data_mem[miss_way][miss_idx] <= mem_data_i;
      tag_mem[miss_way][miss_idx]  <= miss_tag;
    end else if (wr_hit) begin
      data_mem[hit_way][req_idx][word_bit +: 32] <= p1_data_i;
    end
  end

  // Valid, dirty and LRU bookkeeping; cleared by reset.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int s = 0; s < SETS; s++) begin
        valid_q[s] <= 2'b00;
        dirty_q[s] <= 2'b00;
      end
      lru_q <= '0;
    end else begin
      if (fill_we) begin
        valid_q[miss_idx][miss_way] <= 1'b1;
        dirty_q[miss_idx][miss_way] <= 1'b0;
      end
      if (hit) begin
        lru_q[req_idx] <= ~hit_way;
        if (p1_MemWrite_i) begin
          dirty_q[req_idx][hit_way] <= 1'b1;
        end
      end
    end
  end

  // Miss controller with registered memory request outputs.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state        <= S_IDLE;
      mem_enable_o <= 1'b0;
      mem_write_o  <= 1'b0;
      mem_addr_o   <= '0;
      mem_data_o   <= '0;
      miss_tag     <= '0;
      miss_idx     <= '0;
      miss_way     <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (req && !hit) begin
            miss_tag <= req_tag;
            miss_idx <= req_idx;
            miss_way <= vic_way;
            state    <= S_MISS;
          end
        end
        S_MISS: begin
          mem_enable_o <= 1'b1;
          if (vic_valid && vic_dirty) begin
            mem_write_o <= 1'b1;
            mem_addr_o  <= {vic_tag, miss_idx, {OFF_W{1'b0}}};
            mem_data_o  <= vic_line;
            state       <= S_WRITEBACK;
          end else begin
            mem_write_o <= 1'b0;
            mem_addr_o  <= {miss_tag, miss_idx, {OFF_W{1'b0}}};
            state       <= S_READMISS;
          end
        end
        S_WRITEBACK: begin
          if (mem_ack_i) begin
            mem_write_o <= 1'b0;
            mem_addr_o  <= {miss_tag, miss_idx, {OFF_W{1'b0}}};
            state       <= S_READMISS;
          end
        end
        S_READMISS: begin
          if (mem_ack_i) begin
            mem_enable_o <= 1'b0;
            state        <= S_READMISSOK;
          end
        end
        S_READMISSOK: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dcache_2way_top.sv
// Bench for dcache_2way_top. A reference model (flat CPU-visible memory plus
// per-set recency lists) predicts read data and memory transactions; a CPU
// monitor and a memory responder pop those expectations as the DUT presents
// them.
module tb_dcache_2way_top;

  localparam int LINE_W = 256;
  localparam int SETS   = 32;
  localparam int ADDR_W = 32;

  // Memory handshake: mem_enable_o is valid; the request fields must stay
  // stable until mem_ack_i is sampled high at a rising edge; ack is ignored
  // while no request is pending.

  logic              clk_i = 1'b0;
  logic              rst_i = 1'b0;
  logic [LINE_W-1:0] mem_data_i = '0;
  logic              mem_ack_i = 1'b0;
  logic [LINE_W-1:0] mem_data_o;
  logic [ADDR_W-1:0] mem_addr_o;
  logic              mem_enable_o;
  logic              mem_write_o;
  logic [31:0]       p1_data_i = '0;
  logic [ADDR_W-1:0] p1_addr_i = '0;
  logic              p1_MemRead_i = 1'b0;
  logic              p1_MemWrite_i = 1'b0;
  logic [31:0]       p1_data_o;
  logic              p1_stall_o;
  logic [2:0]        dbg_state;

  dcache_2way_top #(.LINE_W(LINE_W), .SETS(SETS), .ADDR_W(ADDR_W)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .mem_data_i(mem_data_i), .mem_ack_i(mem_ack_i),
    .mem_data_o(mem_data_o), .mem_addr_o(mem_addr_o),
    .mem_enable_o(mem_enable_o), .mem_write_o(mem_write_o),
    .p1_data_i(p1_data_i), .p1_addr_i(p1_addr_i),
    .p1_MemRead_i(p1_MemRead_i), .p1_MemWrite_i(p1_MemWrite_i),
    .p1_data_o(p1_data_o), .p1_stall_o(p1_stall_o),
    .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk_i = ~clk_i;

  int cyc = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  // ---------------- scoreboard state ----------------
  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [255:0] data;
  } mem_txn_t;

  logic [31:0]  exp_q[$];
  mem_txn_t     mem_exp_q[$];
  logic [255:0] ram     [int unsigned];
  logic [255:0] ref_mem [int unsigned];
  int unsigned  set_lines [SETS][$];
  bit           dirty_m [int unsigned];

  int checks = 0;
  int errors = 0;
  int last_fill_cyc = 0;
  int force_lat = 0;
  bit stall_ack = 1'b0;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic logic [255:0] init_line(input logic [31:0] la);
    logic [255:0] l;
    for (int w = 0; w < 8; w++) l[w*32 +: 32] = (la + 32'(w * 4)) ^ 32'hA5C3_0000;
    return l;
  endfunction

  function automatic logic [255:0] ram_line(input logic [31:0] la);
    return ram.exists(la) ? ram[la] : init_line(la);
  endfunction

  function automatic logic [255:0] ref_line(input logic [31:0] la);
    return ref_mem.exists(la) ? ref_mem[la] : init_line(la);
  endfunction

  // Reference model: the cache is transparent to the CPU, so read data comes
  // from a flat memory; eviction follows a per-set recency list (oldest first).
  task automatic model_access(input bit wr, input logic [31:0] addr,
                              input logic [31:0] data, output bit hit);
    logic [31:0]  la;
    int           s;
    int           pos;
    logic [7:0]   off;
    logic [255:0] line;
    mem_txn_t     t;
    la  = addr & 32'hFFFF_FFE0;
    s   = int'(addr[9:5]);
    off = {addr[4:2], 5'b0_0000};
    hit = 1'b0;
    pos = 0;
    for (int i = 0; i < set_lines[s].size(); i++)
      if (set_lines[s][i] == la) begin hit = 1'b1; pos = i; end
    if (hit) begin
      set_lines[s].delete(pos);
      set_lines[s].push_back(la);
    end else begin
      if (set_lines[s].size() == 2) begin
        logic [31:0] v;
        v = set_lines[s].pop_front();
        if (dirty_m.exists(v) && dirty_m[v]) begin
          t.wr = 1'b1; t.addr = v; t.data = ref_line(v);
          mem_exp_q.push_back(t);
        end
        dirty_m.delete(v);
      end
      t.wr = 1'b0; t.addr = la; t.data = '0;
      mem_exp_q.push_back(t);
      set_lines[s].push_back(la);
      dirty_m[la] = 1'b0;
    end
    line = ref_line(la);
    if (wr) begin
      line[off +: 32] = data;
      ref_mem[la] = line;
      dirty_m[la] = 1'b1;
    end else begin
      exp_q.push_back(line[off +: 32]);
    end
  endtask

  // After reset the cache forgets everything, including unwritten dirty data.
  task automatic model_reset();
    for (int s = 0; s < SETS; s++) set_lines[s].delete();
    dirty_m.delete();
    ref_mem = ram;
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive_access(input bit wr, input logic [31:0] addr,
                              input logic [31:0] data, input bit exp_hit);
    int  n;
    bit  done;
    @(posedge clk_i); #1;
    p1_addr_i     = addr;
    p1_data_i     = data;
    p1_MemRead_i  = ~wr;
    p1_MemWrite_i = wr;
    n = 0;
    done = 1'b0;
    while (!done) begin
      @(negedge clk_i);
      if (!p1_stall_o) done = 1'b1;
      else begin
        n++;
        if (n > 500) begin
          checks++; errors++;
          $display("FAIL stall_timeout actual=%0d cycles required=<=500", n);
          done = 1'b1;
        end
      end
    end
    if (exp_hit) check("hit_no_stall", 256'(n), 256'd0);
    else         check("miss_resume_delay", 256'(cyc - last_fill_cyc), 256'd1);
    @(posedge clk_i); #1;
    p1_MemRead_i  = 1'b0;
    p1_MemWrite_i = 1'b0;
  endtask

  task automatic access(input bit wr, input logic [31:0] addr, input logic [31:0] data);
    bit hit;
    model_access(wr, addr, data, hit);
    drive_access(wr, addr, data, hit);
  endtask

  // ---------------- CPU monitor ----------------
  initial begin
    logic [31:0] e;
    forever begin
      @(negedge clk_i);
      if (!rst_i && p1_MemRead_i && !p1_stall_o) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL read_unexpected actual=%0h required=none", p1_data_o);
        end else begin
          e = exp_q.pop_front();
          check("read_data", 256'(p1_data_o), 256'(e));
        end
      end else if (!rst_i && (p1_MemRead_i || p1_MemWrite_i)) begin
        check("data_zero_no_read_hit", 256'(p1_data_o), 256'd0);
      end
    end
  end

  // ---------------- memory responder / monitor ----------------
  initial begin
    mem_txn_t     e;
    logic         w;
    logic [31:0]  a;
    logic [255:0] d;
    int           lat;
    int           n;
    forever begin
      @(negedge clk_i);
      if (!rst_i && mem_enable_o) begin
        if (mem_exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL mem_unexpected actual=%0h write=%0d required=none", mem_addr_o, mem_write_o);
        end else begin
          e = mem_exp_q.pop_front();
          check("mem_write", 256'(mem_write_o), 256'(e.wr));
          check("mem_addr", 256'(mem_addr_o), 256'(e.addr));
          if (e.wr) check("mem_wb_data", mem_data_o, e.data);
        end
        w = mem_write_o; a = mem_addr_o; d = mem_data_o;
        if (stall_ack) begin
          n = 0;
          while (mem_enable_o && n < 200) begin @(negedge clk_i); n++; end
        end else begin
          lat = (force_lat > 0) ? force_lat : $urandom_range(0, 3);
          repeat (lat) begin
            @(negedge clk_i);
            if (!rst_i)
              check("mem_stable", {mem_enable_o, mem_write_o, mem_addr_o, mem_data_o[221:0]},
                                  {1'b1, w, a, d[221:0]});
          end
          if (w) ram[a] = d;
          else   mem_data_i = ram_line(a);
          mem_ack_i = 1'b1;
          @(posedge clk_i); #1;
          mem_ack_i = 1'b0;
          if (!w) last_fill_cyc = cyc;
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [255:0] pl;
    logic [31:0]  addr;
    bit           hit;
    int           n;

    #1 rst_i = 1'b1;
    repeat (3) @(negedge clk_i);
    check("rst_mem_enable", 256'(mem_enable_o), 256'd0);
    check("rst_mem_write", 256'(mem_write_o), 256'd0);
    check("rst_mem_addr", 256'(mem_addr_o), 256'd0);
    check("rst_mem_data", mem_data_o, 256'd0);
    check("rst_stall", 256'(p1_stall_o), 256'd0);
    check("rst_state", 256'(dbg_state), 256'd0);

    pl = init_line(32'h400);
    pl[63:32] = 32'h1111_1111;
    ram[32'h400] = pl;
    ref_mem[32'h400] = pl;
    rst_i = 1'b0;

    // Cold miss, then two lines in one set, then re-reads that must hit.
    access(0, 32'h0000_0404, 0);
    access(0, 32'h0000_0000, 0);
    access(0, 32'h0000_0400, 0);
    access(0, 32'h0000_0000, 0);
    // Write hit and neighbouring words.
    access(1, 32'h0000_0004, 32'hDEAD_BEEF);
    access(0, 32'h0000_0004, 0);
    access(0, 32'h0000_0000, 0);
    access(0, 32'h0000_001C, 0);
    // Make the dirty line LRU, then force its eviction.
    access(0, 32'h0000_0400, 0);
    access(0, 32'h0000_0800, 0);
    access(0, 32'h0000_0404, 0);
    access(0, 32'h0000_0004, 0);
    // Long memory latency.
    force_lat = 20;
    access(0, 32'h0000_1008, 0);
    force_lat = 0;

    // Ack with no request pending must not move the controller.
    @(negedge clk_i);
    mem_ack_i = 1'b1;
    repeat (3) begin
      @(negedge clk_i);
      check("spurious_ack_enable", 256'(mem_enable_o), 256'd0);
      check("spurious_ack_state", 256'(dbg_state), 256'd0);
    end
    mem_ack_i = 1'b0;
    access(0, 32'h0000_1008, 0);

    // Randomized traffic over a few sets and conflicting tags.
    for (int i = 0; i < 300; i++) begin
      addr = (32'($urandom_range(0, 3)) << 10) | (32'($urandom_range(0, 3)) << 5) |
             (32'($urandom_range(0, 7)) << 2) | 32'($urandom_range(0, 3));
      access(1'($urandom_range(0, 1)), addr, $urandom);
    end

    check("exp_q_drained", 256'(exp_q.size()), 256'd0);
    check("mem_exp_q_drained", 256'(mem_exp_q.size()), 256'd0);

    // Reset in the middle of a write-back.
    @(negedge clk_i); rst_i = 1'b1;
    @(negedge clk_i); rst_i = 1'b0;
    model_reset();
    access(1, 32'h0000_0804, 32'h1234_5678);
    access(0, 32'h0000_0404, 0);
    stall_ack = 1'b1;
    model_access(0, 32'h0000_0C00, 0, hit);
    @(posedge clk_i); #1;
    p1_addr_i = 32'h0000_0C00;
    p1_MemRead_i = 1'b1;
    n = 0;
    do begin
      @(negedge clk_i);
      n++;
    end while (!(mem_enable_o && mem_write_o) && n < 50);
    check("wb_reached_state", 256'(dbg_state), 256'd2);
    #2 rst_i = 1'b1;
    #1;
    check("async_rst_enable", 256'(mem_enable_o), 256'd0);
    check("async_rst_write", 256'(mem_write_o), 256'd0);
    check("async_rst_addr", 256'(mem_addr_o), 256'd0);
    check("async_rst_data", mem_data_o, 256'd0);
    p1_MemRead_i = 1'b0;
    @(negedge clk_i);
    @(negedge clk_i);
    rst_i = 1'b0;
    stall_ack = 1'b0;
    exp_q.delete();
    mem_exp_q.delete();
    model_reset();
    access(0, 32'h0000_0400, 0);
    access(0, 32'h0000_0804, 0);

    repeat (4) @(negedge clk_i);
    check("final_exp_q_drained", 256'(exp_q.size()), 256'd0);
    check("final_mem_exp_q_drained", 256'(mem_exp_q.size()), 256'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
